nios_key_debounce_ctrl: RTL and testbench

//   Avalon-MM slave controller for the push-button keys feeding the Nios system.
//   - Synchronises and debounces each raw key input.
//   - Latches press events in a per-bit edge-capture register.
//   - Raises a maskable level interrupt to the CPU.

---
 rtl/nios_key_pkg.sv | 18 +
 rtl/nios_key_debounce_ctrl_ch.sv | 80 ++++++++
 rtl/nios_key_debounce_ctrl.sv | 98 +++++++++
 tb/tb_nios_key_debounce_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_key_pkg.sv
// Shared definitions for the Nios push-button key controller.
// Register map, edge-mode encodings and debounce FSM states.
package nios_key_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_FALL = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic {
    ST_STABLE,
    ST_SETTLING
  } deb_state_e;

endpackage

// File: rtl/nios_key_debounce_ctrl_ch.sv
// One key channel: 2-flop synchroniser, settle counter, debounced level.
// Ports: clk_i, rst_i (sync, high), raw_i; deb_o level, rise_o/fall_o 1-cycle pulses.
module key_debounce_ch
  import nios_key_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      deb_q   <= RESET_LEVEL;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The change pulse fires in the cycle the new level is committed, so
  // edge capture and the DATA level update on the same clock edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    rise_o  = 1'b0;
    fall_o  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync2_q != deb_q) begin
          state_d = ST_SETTLING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SETTLING: begin
        if (sync2_q == deb_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          deb_d   = sync2_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
          rise_o  = sync2_q;
          fall_o  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/nios_key_debounce_ctrl.sv
// Avalon-MM key controller: debounced levels, W1C edge capture, masked irq.
// Ports: clk, reset, in_port; address/chipselect/write_n/writedata; readdata, irq.
module nios_key_debounce_ctrl
  import nios_key_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_MODE       = 0,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic             irq_q;
  logic             irq_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clk_i (clk),
      .rst_i (reset),
      .raw_i (in_port[i]),
      .deb_o (deb_v[i]),
      .rise_o(rise_v[i]),
      .fall_o(fall_v[i])
    );
  end

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  assign set_v =
    (EDGE_MODE == EDGE_RISE) ? rise_v :
    (EDGE_MODE == EDGE_BOTH) ? (rise_v | fall_v) :
    fall_v;

  assign clr_v = (wr_en && address == ADDR_EDGECAP)
               ? writedata[WIDTH-1:0] : '0;

  // Set is OR-ed after the clear so a same-cycle capture survives a W1C.
  assign edgecap_d = (edgecap_q & ~clr_v) | set_v;

  assign irqmask_d = (wr_en && address == ADDR_IRQMASK)
                   ? writedata[WIDTH-1:0] : irqmask_q;

  assign irq_d = |(edgecap_q & irqmask_q);

  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = deb_v;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios_key_debounce_ctrl.sv
// Scoreboard bench for nios_key_debounce_ctrl (DEBOUNCE_CYCLES=8, WIDTH=4).
// Stimulus pushes expected read responses; a monitor pops and compares them.
module tb_nios_key_debounce_ctrl;
  import nios_key_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  typedef struct {
    logic [31:0] data;
    bit          chk_irq;
    logic        irq;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_pend = 1'b0;

  nios_key_debounce_ctrl #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(8),
    .EDGE_MODE      (0),
    .RESET_LEVEL    (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // A read sampled at a rising edge presents its data after that edge.
  always @(posedge clk) rd_pend <= chipselect & write_n;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: readdata=%h with no expected entry", readdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (readdata !== e.data) begin
          errors++;
          $display("FAIL %s readdata: got %h want %h", e.name, readdata, e.data);
        end
        if (e.chk_irq) begin
          checks++;
          if (irq !== e.irq) begin
            errors++;
            $display("FAIL %s irq: got %b want %b", e.name, irq, e.irq);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] d,
                    input bit ci, input logic iv, input string n);
    exp_t e;
    e.data    = d;
    e.chk_irq = ci;
    e.irq     = iv;
    e.name    = n;
    q.push_back(e);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Last reset cycle carries a DATA read: reset must force readdata to 0.
  task automatic do_reset(input int n);
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (n - 1) tick();
    rd(ADDR_DATA, 32'h0, 1'b1, 1'b0, "reset_readdata");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tick();

    // 1: reset state, then keys held low through reset
    do_reset(3);
    rd(ADDR_DATA,    32'hF, 1'b1, 1'b0, "t1_data");
    rd(ADDR_EDGECAP, 32'h0, 1'b1, 1'b0, "t1_ecap");
    in_port = 4'h0;
    do_reset(2);
    for (int i = 0; i < 9; i++)
      rd(ADDR_EDGECAP, 32'h0, 1'b0, 1'b0, "t1_no_early_cap");
    rd(ADDR_DATA,    32'hF, 1'b0, 1'b0, "t1_hold_9");
    rd(ADDR_DATA,    32'h0, 1'b0, 1'b0, "t1_settled_10");
    rd(ADDR_EDGECAP, 32'hF, 1'b1, 1'b0, "t1_cap_after");
    in_port = 4'hF;
    do_reset(2);

    // 2: clean press of key 0
    in_port = 4'hE;
    repeat (9) tick();
    rd(ADDR_DATA,    32'hF, 1'b0, 1'b0, "t2_hold_9");
    rd(ADDR_DATA,    32'hE, 1'b0, 1'b0, "t2_press_10");
    rd(ADDR_EDGECAP, 32'h1, 1'b1, 1'b0, "t2_ecap");

    // 4: interrupt masking and W1C
    rd(ADDR_IRQMASK, 32'h0, 1'b1, 1'b0, "t4_mask_rst");
    wr(ADDR_IRQMASK, 32'hFFFF_FFF1);
    rd(ADDR_IRQMASK, 32'h1, 1'b1, 1'b1, "t4_irq_rise");
    wr(ADDR_EDGECAP, 32'h0);
    rd(ADDR_EDGECAP, 32'h1, 1'b1, 1'b1, "t4_w1c_zero");
    wr(ADDR_IRQMASK, 32'h0);
    rd(ADDR_EDGECAP, 32'h1, 1'b1, 1'b0, "t4_mask_keeps_cap");
    wr(ADDR_IRQMASK, 32'h1);
    rd(ADDR_IRQMASK, 32'h1, 1'b1, 1'b1, "t4_remask");
    wr(ADDR_EDGECAP, 32'h1);
    rd(ADDR_EDGECAP, 32'h0, 1'b1, 1'b0, "t4_irq_fall");

    // 3: bouncing key 1, then a short glitch on key 3
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (2) tick();
    in_port = 4'hC;
    repeat (9) tick();
    rd(ADDR_DATA,    32'hE, 1'b0, 1'b0, "t3_bounce_hold");
    rd(ADDR_DATA,    32'hC, 1'b0, 1'b0, "t3_bounce_done");
    rd(ADDR_EDGECAP, 32'h2, 1'b1, 1'b0, "t3_one_cap");
    in_port = 4'h4;
    repeat (5) tick();
    in_port = 4'hC;
    repeat (12) tick();
    rd(ADDR_DATA,    32'hC, 1'b0, 1'b0, "t3_glitch_data");
    rd(ADDR_EDGECAP, 32'h2, 1'b1, 1'b0, "t3_glitch_nocap");

    // 5: W1C colliding with key 2 capture
    in_port = 4'h8;
    repeat (9) tick();
    wr(ADDR_EDGECAP, 32'h6);
    rd(ADDR_EDGECAP, 32'h4, 1'b1, 1'b0, "t5_set_wins");
    rd(2'd2,         32'h0, 1'b0, 1'b0, "t5_reserved");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(ADDR_IRQMASK, 32'h1, 1'b0, 1'b0, "t5_reserved_wr");

    // 6: reset while key 3 is mid-settle
    in_port = 4'h0;
    repeat (7) tick();
    do_reset(2);
    rd(ADDR_DATA,    32'hF, 1'b1, 1'b0, "t6_data");
    rd(ADDR_EDGECAP, 32'h0, 1'b0, 1'b0, "t6_ecap");
    repeat (6) tick();
    rd(ADDR_EDGECAP, 32'h0, 1'b0, 1'b0, "t6_no_event");
    rd(ADDR_DATA,    32'hF, 1'b0, 1'b0, "t6_restart_hold");
    rd(ADDR_DATA,    32'h0, 1'b0, 1'b0, "t6_restart_done");
    rd(ADDR_IRQMASK, 32'h0, 1'b1, 1'b0, "t6_mask_rst");

    repeat (3) tick();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_reads: %0d responses outstanding, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
